// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_pkg
//  Purpose : Shared types and constants for the hazard control unit:
//            forwarding-mux select encoding, MDU stall FSM states and the
//            result-source code that marks a load in the E stage.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package hazard_pkg;

  // Operand source select for the E-stage ALU input muxes
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // register file value read in D
    FWD_WB  = 2'b01,  // result being written back in W
    FWD_MEM = 2'b10   // ALU result sitting in M
  } fwd_sel_e;

  // Multi-cycle MDU stall FSM
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  // result_src value that identifies a load instruction
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_fwd_sel
//  Purpose : Combinational forwarding select for one E-stage source operand.
//            The M stage has priority over W when both write the same rd,
//            because M holds the younger value. Writes to x0 never forward.
//  Ports   : rs_e_i          source register of the operand in E
//            rd_m_i/rd_w_i   destination registers in M / W
//            reg_write_m_i/reg_write_w_i  writeback enables in M / W
//            fwd_o           00 regfile, 01 W result, 10 M ALU result
//  Rev     : 1.0  initial release
// ============================================================================
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_e_i,
  input  logic [REG_ADDR_W-1:0] rd_m_i,
  input  logic [REG_ADDR_W-1:0] rd_w_i,
  input  logic                  reg_write_m_i,
  input  logic                  reg_write_w_i,
  output logic [1:0]            fwd_o
);

  logic w_hit_m;
  logic w_hit_w;

  assign w_hit_m = reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i);
  assign w_hit_w = reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i);

  always_comb begin
    fwd_o = FWD_RF;
    if (w_hit_m) begin
      fwd_o = FWD_MEM;
    end else if (w_hit_w) begin
      fwd_o = FWD_WB;
    end
  end

endmodule : hazard_fwd_sel
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_control_unit
//  Purpose : Stall / flush and forwarding control for the IF/ID, ID/EX and
//            EX/MEM pipeline registers: load-use stalls, taken branch/jump
//            flushes, M/W->E forwarding and a multi-cycle MDU stall FSM with
//            start/done handshake and a sticky watchdog error.
//  Config  : HAZARD_PERF_CNT_EN adds saturating stall/flush cycle counters.
//  Ports   : clk_i, rst_i (sync, active-high)
//            rs1_d_i, rs2_d_i            sources of the instruction in D
//            rs1_e_i, rs2_e_i            sources of the instruction in E
//            rd_e_i, rd_m_i, rd_w_i      destinations in E / M / W
//            result_src_e_i              2'b01 = load in E
//            reg_write_m_i, reg_write_w_i writeback enables in M / W
//            pc_src_e_i                  taken branch/jump resolved in E
//            mdu_req_e_i, mdu_done_i     MDU op in E / result valid pulse
//            forward_a_e_o, forward_b_e_o operand forwarding selects
//            stall_f_o, stall_d_o, stall_e_o  hold PC / IF-ID / ID-EX
//            flush_d_o, flush_e_o        clear IF-ID / ID-EX
//            mdu_start_o, mdu_busy_o, mdu_err_o  MDU handshake and status
//            stall_cycles_o, flush_cycles_o  (HAZARD_PERF_CNT_EN only)
//  Rev     : 1.0  initial release
// ============================================================================
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MDU_TIMEOUT = 64
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] rs1_d_i,
  input  logic [REG_ADDR_W-1:0] rs2_d_i,
  input  logic [REG_ADDR_W-1:0] rs1_e_i,
  input  logic [REG_ADDR_W-1:0] rs2_e_i,
  input  logic [REG_ADDR_W-1:0] rd_e_i,
  input  logic [REG_ADDR_W-1:0] rd_m_i,
  input  logic [REG_ADDR_W-1:0] rd_w_i,
  input  logic [1:0]            result_src_e_i,
  input  logic                  reg_write_m_i,
  input  logic                  reg_write_w_i,
  input  logic                  pc_src_e_i,
  input  logic                  mdu_req_e_i,
  input  logic                  mdu_done_i,
  output logic [1:0]            forward_a_e_o,
  output logic [1:0]            forward_b_e_o,
  output logic                  stall_f_o,
  output logic                  stall_d_o,
  output logic                  stall_e_o,
  output logic                  flush_d_o,
  output logic                  flush_e_o,
  output logic                  mdu_start_o,
  output logic                  mdu_busy_o,
  output logic                  mdu_err_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      stall_cycles_o,
  output logic [CNT_W-1:0]      flush_cycles_o
`endif
);

  // Watchdog counter only needs to reach MDU_TIMEOUT-1
  localparam int unsigned c_cnt_w = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MDU_TIMEOUT - 1);

  mdu_state_e         r_state;
  mdu_state_e         w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_err;

  logic w_lw_stall;
  logic w_timeout;
  logic w_start;
  logic w_stall_f;
  logic w_stall_d;
  logic w_stall_e;
  logic w_flush_d;
  logic w_flush_e;

  // --------------------------------------------------------------------------
  // Operand forwarding
  // --------------------------------------------------------------------------
  hazard_fwd_sel #(
    .REG_ADDR_W    (REG_ADDR_W)
  ) u_fwd_a (
    .rs_e_i        (rs1_e_i),
    .rd_m_i        (rd_m_i),
    .rd_w_i        (rd_w_i),
    .reg_write_m_i (reg_write_m_i),
    .reg_write_w_i (reg_write_w_i),
    .fwd_o         (forward_a_e_o)
  );

  hazard_fwd_sel #(
    .REG_ADDR_W    (REG_ADDR_W)
  ) u_fwd_b (
    .rs_e_i        (rs2_e_i),
    .rd_m_i        (rd_m_i),
    .rd_w_i        (rd_w_i),
    .reg_write_m_i (reg_write_m_i),
    .reg_write_w_i (reg_write_w_i),
    .fwd_o         (forward_b_e_o)
  );

  // --------------------------------------------------------------------------
  // Load-use detection: load in E whose rd is consumed by the instruction in D
  // --------------------------------------------------------------------------
  assign w_lw_stall = (result_src_e_i == RESULT_SRC_LOAD) && (rd_e_i != '0) &&
                      ((rd_e_i == rs1_d_i) || (rd_e_i == rs2_d_i));

  // --------------------------------------------------------------------------
  // MDU FSM next state and stall/flush outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_start     = 1'b0;
    w_stall_f   = 1'b0;
    w_stall_d   = 1'b0;
    w_stall_e   = 1'b0;
    w_flush_d   = 1'b0;
    w_flush_e   = 1'b0;

    if (rst_i) begin
      // Squash D and E while the core is held in reset
      w_state_nxt = IDLE;
      w_flush_d   = 1'b1;
      w_flush_e   = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (mdu_req_e_i) begin
            // Freeze the whole front end; any done seen now is stale
            w_start     = 1'b1;
            w_stall_f   = 1'b1;
            w_stall_d   = 1'b1;
            w_stall_e   = 1'b1;
            w_state_nxt = BUSY;
          end else begin
            w_stall_f = w_lw_stall;
            w_stall_d = w_lw_stall;
            w_flush_d = pc_src_e_i;
            w_flush_e = w_lw_stall | pc_src_e_i;
          end
        end
        BUSY: begin
          // Flushes stay low: a stalled pipeline cannot resolve a branch
          if (mdu_done_i) begin
            // Release in the done cycle so the MDU result advances out of E
            w_state_nxt = IDLE;
          end else if (r_cnt == c_cnt_last) begin
            w_timeout   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == BUSY) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign stall_f_o   = w_stall_f;
  assign stall_d_o   = w_stall_d;
  assign stall_e_o   = w_stall_e;
  assign flush_d_o   = w_flush_d;
  assign flush_e_o   = w_flush_e;
  assign mdu_start_o = w_start;
  assign mdu_busy_o  = (r_state == BUSY);
  assign mdu_err_o   = r_err;

`ifdef HAZARD_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_cycles;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else begin
      if (w_stall_d && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_flush_e && (r_flush_cycles != {CNT_W{1'b1}})) begin
        r_flush_cycles <= r_flush_cycles + 1'b1;
      end
    end
  end

  assign stall_cycles_o = r_stall_cycles;
  assign flush_cycles_o = r_flush_cycles;
`endif

endmodule : hazard_control_unit
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
//  Module  : tb_hazard_control_unit
//  Purpose : Self-checking bench for hazard_control_unit (MDU_TIMEOUT = 8).
//            A cycle-level model predicts every output each cycle; directed
//            literal expectations pin the model at key points.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_hazard_control_unit;

  localparam int AW = 5;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic [1:0]    res_src;
  logic          rwm, rww, pc_src, req, done;

  logic [1:0]    fa, fb;
  logic          sf, sd, se, fd, fe, start, busy, err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  hazard_control_unit #(
    .REG_ADDR_W     (AW),
    .MDU_TIMEOUT    (TO)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .CNT_W          (32)
`endif
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rs1_d_i        (rs1_d),
    .rs2_d_i        (rs2_d),
    .rs1_e_i        (rs1_e),
    .rs2_e_i        (rs2_e),
    .rd_e_i         (rd_e),
    .rd_m_i         (rd_m),
    .rd_w_i         (rd_w),
    .result_src_e_i (res_src),
    .reg_write_m_i  (rwm),
    .reg_write_w_i  (rww),
    .pc_src_e_i     (pc_src),
    .mdu_req_e_i    (req),
    .mdu_done_i     (done),
    .forward_a_e_o  (fa),
    .forward_b_e_o  (fb),
    .stall_f_o      (sf),
    .stall_d_o      (sd),
    .stall_e_o      (se),
    .flush_d_o      (fd),
    .flush_e_o      (fe),
    .mdu_start_o    (start),
    .mdu_busy_o     (busy),
    .mdu_err_o      (err)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles_o (stall_cnt),
    .flush_cycles_o (flush_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: MDU episode tracked as "busy" plus number of busy cycles elapsed
  // --------------------------------------------------------------------------
  bit   m_busy = 1'b0;
  bit   m_err  = 1'b0;
  int   m_cycles = 0;
  int   m_scnt = 0;
  int   m_fcnt = 0;
  bit   cmp_en = 1'b0;

  logic [1:0] e_fa, e_fb;
  logic       e_sf, e_sd, e_se, e_fd, e_fe, e_start;

  function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
    if (rwm && rd_m != 0 && rd_m == rs) return 2'b10;
    if (rww && rd_w != 0 && rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic void compute_exp();
    logic lw;
    lw = (res_src == 2'b01) && (rd_e != 0) && (rd_e == rs1_d || rd_e == rs2_d);
    e_fa = fwd(rs1_e);
    e_fb = fwd(rs2_e);
    e_sf = 0; e_sd = 0; e_se = 0; e_fd = 0; e_fe = 0; e_start = 0;
    if (rst) begin
      e_fd = 1; e_fe = 1;
    end else if (!m_busy) begin
      if (req) begin
        e_start = 1; e_sf = 1; e_sd = 1; e_se = 1;
      end else begin
        e_sf = lw; e_sd = lw; e_fd = pc_src; e_fe = lw | pc_src;
      end
    end else begin
      // The final busy cycle (done, or the TO-th cycle) releases the stalls
      e_sf = !(done || m_cycles == TO - 1);
      e_sd = e_sf;
      e_se = e_sf;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_err    <= 1'b0;
      m_cycles <= 0;
      m_scnt   <= 0;
      m_fcnt   <= 0;
      cmp_en   <= 1'b1;
    end else begin
      m_scnt <= m_scnt + (e_sd ? 1 : 0);
      m_fcnt <= m_fcnt + (e_fe ? 1 : 0);
      if (!m_busy) begin
        if (req) begin
          m_busy   <= 1'b1;
          m_cycles <= 0;
        end
      end else if (done) begin
        m_busy <= 1'b0;
      end else if (m_cycles == TO - 1) begin
        m_busy <= 1'b0;
        m_err  <= 1'b1;
      end else begin
        m_cycles <= m_cycles + 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    compute_exp();
    if (cmp_en) begin
      check("cmp_fwd_a", 32'(fa), 32'(e_fa));
      check("cmp_fwd_b", 32'(fb), 32'(e_fb));
      check("cmp_stall_f", 32'(sf), 32'(e_sf));
      check("cmp_stall_d", 32'(sd), 32'(e_sd));
      check("cmp_stall_e", 32'(se), 32'(e_se));
      check("cmp_flush_d", 32'(fd), 32'(e_fd));
      check("cmp_flush_e", 32'(fe), 32'(e_fe));
      check("cmp_start", 32'(start), 32'(e_start));
      if (!rst) begin
        check("cmp_busy", 32'(busy), 32'(m_busy));
        check("cmp_err", 32'(err), 32'(m_err));
      end
`ifdef HAZARD_PERF_CNT_EN
      if (!rst) begin
        check("cmp_stall_cnt", stall_cnt, 32'(m_scnt));
        check("cmp_flush_cnt", flush_cnt, 32'(m_fcnt));
      end
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // --------------------------------------------------------------------------
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
    res_src = 2'b00; rwm = 0; rww = 0; pc_src = 0; req = 0; done = 0;

    // Reset: flushes asserted, no stalls, no start
    nxt();
    @(negedge clk);
    check("rst_flush_d", 32'(fd), 32'd1);
    check("rst_flush_e", 32'(fe), 32'd1);
    check("rst_stall_f", 32'(sf), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Forwarding priority: M beats W, x0 never forwards
    nxt();
    rwm = 1; rd_m = 5; rww = 1; rd_w = 5; rs1_e = 5; rs2_e = 5;
    @(negedge clk);
    check("fwd_a_mem", 32'(fa), 32'd2);
    check("fwd_b_mem", 32'(fb), 32'd2);
    nxt();
    rd_m = 0;
    @(negedge clk);
    check("fwd_a_wb", 32'(fa), 32'd1);
    nxt();
    rs1_e = 0;
    @(negedge clk);
    check("fwd_a_rf_x0", 32'(fa), 32'd0);
    check("fwd_b_wb", 32'(fb), 32'd1);
    nxt();
    rwm = 0; rww = 0; rs1_e = 0; rs2_e = 0; rd_w = 0;

    // Load-use stall for one cycle, then the bubble moves on
    res_src = 2'b01; rd_e = 7; rs2_d = 7;
    @(negedge clk);
    check("lu_stall_f", 32'(sf), 32'd1);
    check("lu_stall_d", 32'(sd), 32'd1);
    check("lu_flush_e", 32'(fe), 32'd1);
    check("lu_stall_e", 32'(se), 32'd0);
    check("lu_flush_d", 32'(fd), 32'd0);
    nxt();
    res_src = 2'b00; rd_e = 0; rs2_d = 0;
    @(negedge clk);
    check("lu_release", 32'(sd), 32'd0);
    // Load to x0 never stalls
    nxt();
    res_src = 2'b01; rd_e = 0; rs1_d = 0;
    @(negedge clk);
    check("lu_x0_nostall", 32'(sd), 32'd0);
    nxt();
    res_src = 2'b00;

    // Taken branch: flush D and E, no stalls
    pc_src = 1;
    @(negedge clk);
    check("br_flush_d", 32'(fd), 32'd1);
    check("br_flush_e", 32'(fe), 32'd1);
    check("br_stall_d", 32'(sd), 32'd0);
    nxt();
    pc_src = 0;

    // MDU op, done on the 4th busy cycle; done in the start cycle is ignored
    req = 1; done = 1;
    @(negedge clk);
    check("mdu_start", 32'(start), 32'd1);
    check("mdu_start_stall_e", 32'(se), 32'd1);
    check("mdu_start_busy", 32'(busy), 32'd0);
    nxt();
    done = 0;
    @(negedge clk);
    check("mdu_busy1", 32'(busy), 32'd1);
    check("mdu_busy1_start", 32'(start), 32'd0);
    check("mdu_busy1_stall_f", 32'(sf), 32'd1);
    nxt();
    nxt();
    nxt();
    done = 1;
    @(negedge clk);
    check("mdu_done_busy", 32'(busy), 32'd1);
    check("mdu_done_stall_e", 32'(se), 32'd0);
    nxt();
    done = 0; req = 0;
    @(negedge clk);
    check("mdu_idle_busy", 32'(busy), 32'd0);
    check("mdu_idle_err", 32'(err), 32'd0);

    // Watchdog: no done, 8 busy cycles, stalls drop on the last one
    nxt();
    req = 1;
    for (int i = 0; i < TO; i++) begin
      nxt();
      @(negedge clk);
      check("wd_busy", 32'(busy), 32'd1);
      check("wd_stall_e", 32'(se), (i < TO - 1) ? 32'd1 : 32'd0);
    end
    nxt();
    req = 0;
    @(negedge clk);
    check("wd_err_set", 32'(err), 32'd1);
    check("wd_idle", 32'(busy), 32'd0);
    nxt();
    pc_src = 1;
    @(negedge clk);
    check("wd_err_sticky", 32'(err), 32'd1);
    check("wd_flush_after", 32'(fe), 32'd1);
    nxt();
    pc_src = 0;

    // Reset in the middle of a busy episode
    req = 1;
    nxt();
    nxt();
    rst = 1;
    @(negedge clk);
    check("rb_start", 32'(start), 32'd0);
    check("rb_flush_e", 32'(fe), 32'd1);
    check("rb_stall_e", 32'(se), 32'd0);
    nxt();
    rst = 0; req = 0;
    @(negedge clk);
    check("rb_busy", 32'(busy), 32'd0);
    check("rb_err", 32'(err), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("rb_stall_cnt", stall_cnt, 32'd0);
    check("rb_flush_cnt", flush_cnt, 32'd0);
`endif
    nxt();
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_hazard_control_unit
`default_nettype wire
